pwm_duty_decoder: RTL and testbench
===================================

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the period and high-time counters and of the measurement outputs.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on pwm_in, minimum 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pwm_in  input  1  asynchronous PWM bitstream, for example the speaker signal aud_pwm & aud_sd.
REQ-006 meas_period  output  CNT_WIDTH  clk cycles between two consecutive rising edges of pwm_in.
REQ-007 meas_high  output  CNT_WIDTH  clk cycles with pwm_in high within that period.
REQ-008 meas_valid  output  1  a measurement is held on meas_period and meas_high.
REQ-009 meas_ready  input  1  consumer accepts the measurement when meas_valid and meas_ready are both high.
REQ-010 overrun  output  1  sticky flag: a completed measurement was dropped.
REQ-011 timeout  output  1  one-cycle pulse: no rising edge arrived within counter range.

Function
REQ-012 pwm_in shall pass through SYNC_STAGES flops plus one history flop; a rising edge is detected when the synchronized value is 1 and the history value is 0, and a falling edge when it is 1 then 0.
REQ-013 The delay from a pwm_in transition to its detected edge shall be SYNC_STAGES+1 cycles.
REQ-014 The FSM shall have states IDLE, ARM, HIGH and LOW.
REQ-015 The FSM shall move from IDLE to ARM on any cycle where the synchronized level is 0.
REQ-016 The FSM shall move from ARM to HIGH on a rising edge; the period counter and high counter shall both load 1, and no capture occurs.
REQ-017 In HIGH, each cycle shall increment both counters; a falling edge shall move the FSM to LOW and increment the period counter only.
REQ-018 In LOW, each cycle shall increment the period counter only.
REQ-019 A rising edge in LOW shall capture both counter values, reload both counters to 1 and move the FSM to HIGH.
REQ-020 Example: an input with a 10-cycle period and 3 cycles high shall capture meas_period=10 and meas_high=3.
REQ-021 If the period counter reaches 2^CNT_WIDTH-1 in HIGH or LOW, the block shall pulse timeout for one cycle, return to IDLE and not capture; this covers a constant-high or constant-low input.
REQ-022 The output stage shall be a one-entry register; meas_valid shall rise on the cycle after a capture.
REQ-023 While meas_valid is high, meas_period and meas_high shall stay stable until the handshake completes; after a handshake with no new capture, meas_valid shall drop the next cycle.
REQ-024 A capture coinciding with a handshake shall load the new values and keep meas_valid at 1 without a gap.
REQ-025 A capture while meas_valid is high and meas_ready is low shall be dropped, the old values retained and overrun set.
REQ-026 overrun shall remain set until rst.
REQ-027 No glitch filtering is applied; every pulse of at least one cycle after synchronization shall be counted.

Reset
REQ-028 On rst, the FSM shall enter IDLE and the counters, synchronizer flops and history flop shall clear to 0.
REQ-029 On rst, meas_period, meas_high, meas_valid, overrun and timeout shall all read 0 on the cycle after reset is sampled.
REQ-030 Asserting rst mid-measurement shall discard the partial counts; a held but unaccepted measurement shall be lost without setting overrun.
REQ-031 A pwm_in that is high at reset release shall not produce a measurement; the ARM state enforces this.

Structure
REQ-032 The FSM state encoding and the default CNT_WIDTH and SYNC_STAGES values shall live in the shared audio constants package.
REQ-033 The synchronizer chain shall be a separate sub-module named pwm_sync, parameterized by SYNC_STAGES; edge detection, FSM, counters and the output register shall stay in pwm_duty_decoder.

Verification
REQ-034 Drive pwm_in at 10-cycle period, 3 cycles high, with meas_ready=1 -> every measurement reads meas_period=10 and meas_high=3, one meas_valid pulse per period.
REQ-035 Set meas_ready=0 across two completed periods, then 1 -> the first values are held unchanged, overrun=1, and exactly one handshake occurs.
REQ-036 Hold pwm_in high after a rising edge with CNT_WIDTH=16 -> timeout pulses once 65535 cycles after the edge, no meas_valid occurs, and the FSM is in IDLE.
REQ-037 Hold pwm_in=1 through reset release, then apply low, high, low, high with 8-cycle period and 4 cycles high -> no measurement before the second post-reset rising edge, then meas_period=8 and meas_high=4.
REQ-038 Assert rst for one cycle in the middle of the HIGH phase -> all outputs read 0 the next cycle, and the first later measurement is exact.
REQ-039 Time a capture to coincide with a handshake -> meas_valid stays 1 continuously and the new values appear the next cycle.

Source files
------------

// File: rtl/pwm_duty_decoder_pkg.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder_pkg
//
// Shared audio constants for the PWM duty decoder slice: default counter
// width, default synchronizer depth and the measurement FSM state encoding.
// Imported by pwm_sync and pwm_duty_decoder.
// ---------------------------------------------------------------------------
package pwm_duty_decoder_pkg;

  // Default width of the period/high-time counters and measurement outputs.
  localparam int DEFAULT_CNT_WIDTH   = 16;

  // Default number of synchronizer flops on the asynchronous PWM input.
  // Two is the smallest depth that gives metastability settling time.
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Measurement FSM states.
  //   ST_IDLE : waiting to observe a (trusted) low level on the input
  //   ST_ARM  : low level seen, waiting for the first rising edge
  //   ST_HIGH : inside the high phase of a period, counting both counters
  //   ST_LOW  : inside the low phase of a period, counting the period only
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } pwm_state_e;

endpackage : pwm_duty_decoder_pkg

// File: rtl/pwm_sync.sv
// ---------------------------------------------------------------------------
// pwm_sync
//
// Multi-flop synchronizer for the asynchronous PWM input.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, clears the chain
//   async_in   in   asynchronous input bit
//   sync_out   out  synchronized level (last flop of the chain)
//   sync_valid out  high once sync_out holds a genuine sample of async_in
//
// After reset every flop holds 0, which is not a real observation of the
// input. A parallel fill chain shifts in ones so the consumer knows when the
// synchronized level can be trusted; without it, an input that is high at
// reset release would look like a 0 -> 1 transition.
// ---------------------------------------------------------------------------
module pwm_sync
  import pwm_duty_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES  // minimum 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic sync_valid
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] fill_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      fill_reg <= '0;
    end else begin
      // Bit 0 is the metastability-catching flop; the sample moves towards
      // the MSB one stage per cycle.
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_out   = sync_reg[SYNC_STAGES-1];
  assign sync_valid = fill_reg[SYNC_STAGES-1];

endmodule : pwm_sync

// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder
//
// Measures the period and high time of an asynchronous PWM bitstream in
// clk cycles, from one rising edge to the next, and presents each completed
// measurement through a one-entry valid/ready output register.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   pwm_in       in   asynchronous PWM bitstream
//   meas_period  out  cycles between two consecutive rising edges
//   meas_high    out  cycles high within that period
//   meas_valid   out  a measurement is held on meas_period/meas_high
//   meas_ready   in   consumer accepts when meas_valid && meas_ready
//   overrun      out  sticky: a completed measurement was dropped
//   timeout      out  one-cycle pulse: counter saturated without an edge
//
// Pipeline: pwm_in -> SYNC_STAGES synchronizer flops -> history flop. An
// edge is therefore acted upon SYNC_STAGES+1 cycles after pwm_in changes.
// Every edge is delayed by the same amount, so measured intervals are exact.
// ---------------------------------------------------------------------------
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] meas_period,
  output logic [CNT_WIDTH-1:0] meas_high,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic                 overrun,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  // -------------------------------------------------------------------------
  // Synchronizer and edge detection
  // -------------------------------------------------------------------------
  logic sync_level;
  logic sync_valid;
  logic hist_reg;
  logic rise_det;
  logic fall_det;

  pwm_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pwm_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (pwm_in),
    .sync_out   (sync_level),
    .sync_valid (sync_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= 1'b0;
    end else begin
      hist_reg <= sync_level;
    end
  end

  assign rise_det =  sync_level & ~hist_reg;
  assign fall_det = ~sync_level &  hist_reg;

  // -------------------------------------------------------------------------
  // Measurement FSM and counters
  // -------------------------------------------------------------------------
  pwm_state_e           state_reg;
  pwm_state_e           state_next;
  logic [CNT_WIDTH-1:0] period_cnt_reg;
  logic [CNT_WIDTH-1:0] period_cnt_next;
  logic [CNT_WIDTH-1:0] high_cnt_reg;
  logic [CNT_WIDTH-1:0] high_cnt_next;
  logic                 timeout_next;
  logic                 capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      period_cnt_reg <= CNT_ZERO;
      high_cnt_reg   <= CNT_ZERO;
    end else begin
      state_reg      <= state_next;
      period_cnt_reg <= period_cnt_next;
      high_cnt_reg   <= high_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    period_cnt_next = period_cnt_reg;
    high_cnt_next   = high_cnt_reg;
    timeout_next    = 1'b0;
    capture         = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        period_cnt_next = CNT_ZERO;
        high_cnt_next   = CNT_ZERO;
        // Only a genuinely sampled low level arms the decoder, so an input
        // that is high coming out of reset cannot fake a rising edge.
        if (sync_valid && !sync_level) begin
          state_next = ST_ARM;
        end
      end

      ST_ARM: begin
        // First rising edge only starts a period; nothing to capture yet.
        if (rise_det) begin
          state_next      = ST_HIGH;
          period_cnt_next = CNT_ONE;
          high_cnt_next   = CNT_ONE;
        end
      end

      ST_HIGH: begin
        // Saturation check wins over edges: the counters could not have
        // represented the interval, so the measurement is abandoned.
        if (period_cnt_reg == CNT_MAX) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          period_cnt_next = period_cnt_reg + CNT_ONE;
          if (fall_det) begin
            state_next = ST_LOW;
          end else begin
            high_cnt_next = high_cnt_reg + CNT_ONE;
          end
        end
      end

      ST_LOW: begin
        if (period_cnt_reg == CNT_MAX) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (rise_det) begin
          // The rising edge closes this period and opens the next one, so
          // the edge cycle itself is the first cycle of the new period.
          capture         = 1'b1;
          state_next      = ST_HIGH;
          period_cnt_next = CNT_ONE;
          high_cnt_next   = CNT_ONE;
        end else begin
          period_cnt_next = period_cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next      = ST_IDLE;
        period_cnt_next = CNT_ZERO;
        high_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // One-entry output register with valid/ready handshake
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] meas_period_reg;
  logic [CNT_WIDTH-1:0] meas_high_reg;
  logic                 meas_valid_reg;
  logic                 overrun_reg;
  logic                 timeout_reg;
  logic                 slot_free;

  // The slot can take a new capture when empty, or when the held entry is
  // being accepted this very cycle (back-to-back without a valid gap).
  assign slot_free = !meas_valid_reg || meas_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      meas_period_reg <= CNT_ZERO;
      meas_high_reg   <= CNT_ZERO;
      meas_valid_reg  <= 1'b0;
      overrun_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      timeout_reg <= timeout_next;
      if (capture) begin
        if (slot_free) begin
          meas_period_reg <= period_cnt_reg;
          meas_high_reg   <= high_cnt_reg;
          meas_valid_reg  <= 1'b1;
        end else begin
          // Held entry not yet consumed: keep it, drop the new one.
          overrun_reg <= 1'b1;
        end
      end else if (meas_valid_reg && meas_ready) begin
        meas_valid_reg <= 1'b0;
      end
    end
  end

  assign meas_period = meas_period_reg;
  assign meas_high   = meas_high_reg;
  assign meas_valid  = meas_valid_reg;
  assign overrun     = overrun_reg;
  assign timeout     = timeout_reg;

endmodule : pwm_duty_decoder

// File: tb/tb_pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_decoder
//
// Directed scenarios for pwm_duty_decoder with CNT_WIDTH=16, SYNC_STAGES=2.
// Inputs change 1 time unit after the rising clock edge; outputs are read
// either 1 unit after the rising edge or on the falling edge (monitor).
// ---------------------------------------------------------------------------
module tb_pwm_duty_decoder;
  import pwm_duty_decoder_pkg::*;

  localparam int CW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic          meas_ready;
  logic [CW-1:0] meas_period;
  logic [CW-1:0] meas_high;
  logic          meas_valid;
  logic          overrun;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  // Handshake log and pulse counters filled by the monitor.
  logic [CW-1:0] hs_period_q[$];
  logic [CW-1:0] hs_high_q[$];
  int            valid_cycles   = 0;
  int            timeout_cycles = 0;

  always #5 clk = ~clk;

  pwm_duty_decoder #(
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (meas_valid === 1'b1) valid_cycles++;
      if (timeout === 1'b1) timeout_cycles++;
      if (meas_valid === 1'b1 && meas_ready === 1'b1) begin
        hs_period_q.push_back(meas_period);
        hs_high_q.push_back(meas_high);
        $display("handshake period=%0d high=%0d at %0t", meas_period, meas_high, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_pwm(input logic lvl, input int n);
    pwm_in = lvl;
    tick_n(n);
  endtask

  task automatic clear_monitor();
    hs_period_q.delete();
    hs_high_q.delete();
    valid_cycles   = 0;
    timeout_cycles = 0;
  endtask

  task automatic apply_reset(input logic lvl);
    rst    = 1'b1;
    pwm_in = lvl;
    tick_n(3);
    rst = 1'b0;
    clear_monitor();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; pwm_in = 1'b0; meas_ready = 1'b0;
    tick_n(2);
    checks++; if (meas_period !== 16'd0) begin errors++; $display("FAIL reset_period got %0d want 0", meas_period); end
    checks++; if (meas_high !== 16'd0) begin errors++; $display("FAIL reset_high got %0d want 0", meas_high); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", meas_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  // 10-cycle period, 3 high, consumer always ready.
  task automatic test_steady();
    apply_reset(1'b0);
    meas_ready = 1'b1;
    tick_n(5);
    for (int k = 0; k < 6; k++) begin
      drive_pwm(1'b1, 3);
      drive_pwm(1'b0, 7);
    end
    checks++; if (hs_period_q.size() != 5) begin errors++; $display("FAIL steady_count got %0d want 5", hs_period_q.size()); end
    for (int i = 0; i < hs_period_q.size(); i++) begin
      checks++; if (hs_period_q[i] !== 16'd10) begin errors++; $display("FAIL steady_period[%0d] got %0d want 10", i, hs_period_q[i]); end
      checks++; if (hs_high_q[i] !== 16'd3) begin errors++; $display("FAIL steady_high[%0d] got %0d want 3", i, hs_high_q[i]); end
    end
    checks++; if (valid_cycles != 5) begin errors++; $display("FAIL steady_valid_cycles got %0d want 5", valid_cycles); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL steady_overrun got %b want 0", overrun); end
    $display("test_steady done");
  endtask

  // Single-cycle high pulses are counted: 5-cycle period, 1 high.
  task automatic test_narrow_pulse();
    apply_reset(1'b0);
    meas_ready = 1'b1;
    tick_n(5);
    for (int k = 0; k < 3; k++) begin
      drive_pwm(1'b1, 1);
      drive_pwm(1'b0, 4);
    end
    checks++; if (hs_period_q.size() != 2) begin errors++; $display("FAIL narrow_count got %0d want 2", hs_period_q.size()); end
    for (int i = 0; i < hs_period_q.size(); i++) begin
      checks++; if (hs_period_q[i] !== 16'd5 || hs_high_q[i] !== 16'd1) begin
        errors++; $display("FAIL narrow_meas[%0d] got %0d/%0d want 5/1", i, hs_period_q[i], hs_high_q[i]);
      end
    end
    $display("test_narrow_pulse done");
  endtask

  // Two captures while not ready: first held, second dropped, overrun sticky.
  task automatic test_overrun();
    apply_reset(1'b0);
    meas_ready = 1'b0;
    tick_n(5);
    drive_pwm(1'b1, 3); drive_pwm(1'b0, 7);   // period 10 / high 3
    drive_pwm(1'b1, 5); drive_pwm(1'b0, 7);   // period 12 / high 5 (dropped)
    drive_pwm(1'b1, 3); drive_pwm(1'b0, 2);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", meas_valid); end
    checks++; if (meas_period !== 16'd10 || meas_high !== 16'd3) begin
      errors++; $display("FAIL ovr_held got %0d/%0d want 10/3", meas_period, meas_high);
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    meas_ready = 1'b1;
    tick_n(3);
    meas_ready = 1'b0;
    checks++; if (hs_period_q.size() != 1) begin errors++; $display("FAIL ovr_handshakes got %0d want 1", hs_period_q.size()); end
    else begin
      checks++; if (hs_period_q[0] !== 16'd10 || hs_high_q[0] !== 16'd3) begin
        errors++; $display("FAIL ovr_accepted got %0d/%0d want 10/3", hs_period_q[0], hs_high_q[0]);
      end
    end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got %b want 0", meas_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    $display("test_overrun done");
  endtask

  // Capture lands in the same cycle the held entry is accepted.
  task automatic test_back_to_back();
    apply_reset(1'b0);
    meas_ready = 1'b0;
    tick_n(5);
    drive_pwm(1'b1, 3); drive_pwm(1'b0, 7);   // rise 1
    drive_pwm(1'b1, 2); drive_pwm(1'b0, 4);   // rise 2 -> capture 10/3 held
    pwm_in = 1'b1;                            // rise 3 -> capture 6/2
    tick_n(2);
    checks++; if (meas_valid !== 1'b1 || meas_period !== 16'd10) begin
      errors++; $display("FAIL b2b_pre got valid=%b period=%0d want 1/10", meas_valid, meas_period);
    end
    meas_ready = 1'b1;   // handshake in the capture cycle
    tick();
    meas_ready = 1'b0;
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", meas_valid); end
    checks++; if (meas_period !== 16'd6 || meas_high !== 16'd2) begin
      errors++; $display("FAIL b2b_new got %0d/%0d want 6/2", meas_period, meas_high);
    end
    checks++; if (hs_period_q.size() != 1 || hs_period_q[0] !== 16'd10) begin
      errors++; $display("FAIL b2b_accepted got count=%0d want 1 with period 10", hs_period_q.size());
    end
    tick();
    checks++; if (meas_valid !== 1'b1 || meas_period !== 16'd6) begin
      errors++; $display("FAIL b2b_hold got valid=%b period=%0d want 1/6", meas_valid, meas_period);
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    $display("test_back_to_back done");
  endtask

  // Input high through reset release must not yield a measurement.
  task automatic test_high_at_release();
    meas_ready = 1'b1;
    apply_reset(1'b1);
    drive_pwm(1'b1, 6);
    drive_pwm(1'b0, 4);
    drive_pwm(1'b1, 4);   // first post-reset rising edge
    drive_pwm(1'b0, 4);
    checks++; if (valid_cycles != 0) begin errors++; $display("FAIL rel_early got %0d valid cycles want 0", valid_cycles); end
    drive_pwm(1'b1, 4);   // second post-reset rising edge
    drive_pwm(1'b0, 3);
    checks++; if (hs_period_q.size() != 1) begin errors++; $display("FAIL rel_count got %0d want 1", hs_period_q.size()); end
    else begin
      checks++; if (hs_period_q[0] !== 16'd8 || hs_high_q[0] !== 16'd4) begin
        errors++; $display("FAIL rel_meas got %0d/%0d want 8/4", hs_period_q[0], hs_high_q[0]);
      end
    end
    $display("test_high_at_release done");
  endtask

  // One-cycle reset in the HIGH phase with a held entry and overrun set.
  task automatic test_mid_reset();
    apply_reset(1'b0);
    meas_ready = 1'b0;
    tick_n(5);
    drive_pwm(1'b1, 3); drive_pwm(1'b0, 7);
    drive_pwm(1'b1, 3); drive_pwm(1'b0, 7);
    drive_pwm(1'b1, 5);                       // third rise: dropped capture, now in HIGH
    checks++; if (meas_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL mid_setup got valid=%b overrun=%b want 1/1", meas_valid, overrun);
    end
    rst = 1'b1;
    tick();
    checks++; if (meas_period !== 16'd0 || meas_high !== 16'd0) begin
      errors++; $display("FAIL mid_rst_meas got %0d/%0d want 0/0", meas_period, meas_high);
    end
    checks++; if (meas_valid !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags got v=%b o=%b t=%b want 0/0/0", meas_valid, overrun, timeout);
    end
    rst = 1'b0;
    clear_monitor();
    meas_ready = 1'b1;
    drive_pwm(1'b1, 2);
    drive_pwm(1'b0, 5);
    drive_pwm(1'b1, 3); drive_pwm(1'b0, 6);   // arms, period 9 / high 3
    drive_pwm(1'b1, 3); drive_pwm(1'b0, 2);
    checks++; if (hs_period_q.size() != 1) begin errors++; $display("FAIL mid_count got %0d want 1", hs_period_q.size()); end
    else begin
      checks++; if (hs_period_q[0] !== 16'd9 || hs_high_q[0] !== 16'd3) begin
        errors++; $display("FAIL mid_meas got %0d/%0d want 9/3", hs_period_q[0], hs_high_q[0]);
      end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b want 0", overrun); end
    $display("test_mid_reset done");
  endtask

  // Constant high after a rising edge saturates the period counter.
  task automatic test_timeout();
    int n_hit;
    apply_reset(1'b0);
    meas_ready = 1'b1;
    tick_n(5);
    pwm_in = 1'b1;
    n_hit = -1;
    // Edge reaches the FSM after SS+1 edges; the counter then needs 65534
    // more increments to reach 65535 and one more edge to register timeout.
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (timeout === 1'b1) begin
        n_hit = n;
        break;
      end
    end
    checks++; if (n_hit != 65538) begin errors++; $display("FAIL to_latency got %0d want 65538", n_hit); end
    tick_n(3);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got %b want 0", timeout); end
    checks++; if (timeout_cycles != 1) begin errors++; $display("FAIL to_pulses got %0d want 1", timeout_cycles); end
    checks++; if (valid_cycles != 0) begin errors++; $display("FAIL to_valid got %0d want 0", valid_cycles); end
    checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL to_state got %0d want %0d", dut.state_reg, ST_IDLE); end
    $display("test_timeout done");
  endtask

  initial begin
    rst        = 1'b1;
    pwm_in     = 1'b0;
    meas_ready = 1'b0;
    test_reset();
    test_steady();
    test_narrow_pulse();
    test_overrun();
    test_back_to_back();
    test_high_at_release();
    test_mid_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pwm_duty_decoder
